seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_bcd_decoder.sv | 26 ++
 rtl/seg7_scan_driver.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for the timer and word display paths.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/seg7_bcd_decoder.sv
// Combinational BCD to active-low segment lookup; non-BCD codes show a dash.
module seg7_bcd_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-coherent snapshot,
// leading-zero blanking, per-digit blink, decimal points and registered outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned BLINK_HALF = 50000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [SCAN_W-1:0]                scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [BLINK_W-1:0]               blink_cnt_q, blink_cnt_d;
    logic                             blink_phase_q, blink_phase_d;
    logic                             load_pending_q, load_pending_d;
    logic [NUM_DIGITS-1:0][3:0]       sh_digits_q, sh_digits_d;
    logic [NUM_DIGITS-1:0]            sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]            sh_blink_q, sh_blink_d;
    logic                             sh_lz_q, sh_lz_d;
    logic [6:0]                       seg_d;
    logic                             dp_d;
    logic [NUM_DIGITS-1:0]            an_d;
    logic                             frame_done_d;

    logic       tick_c, wrap_c, snap_c, lz_blank_c, blink_blank_c;
    logic [6:0] dec_seg_c;

    seg7_bcd_decoder u_dec (
        .bcd   (sh_digits_q[idx_q]),
        .seg_c (dec_seg_c)
    );

    assign tick_c        = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign wrap_c        = tick_c && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign snap_c        = enable && (load_pending_q || wrap_c);
    assign blink_blank_c = blink_phase_q && sh_blink_q[idx_q];

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        lz_blank_c = sh_lz_q && (idx_q != '0);
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if ((IDX_W'(j) >= idx_q) && (sh_digits_q[j] != 4'd0)) begin
                lz_blank_c = 1'b0;
            end
        end
    end

    // Next-state and registered-output logic; enable=0 freezes counters and darkens the display.
    always_comb begin
        scan_cnt_d     = scan_cnt_q;
        idx_d          = idx_q;
        blink_cnt_d    = blink_cnt_q;
        blink_phase_d  = blink_phase_q;
        load_pending_d = load_pending_q;
        sh_digits_d    = sh_digits_q;
        sh_dp_d        = sh_dp_q;
        sh_blink_d     = sh_blink_q;
        sh_lz_d        = sh_lz_q;
        seg_d          = SEG_BLANK;
        dp_d           = 1'b1;
        an_d           = '1;
        frame_done_d   = snap_c;

        if (enable) begin
            if (load_pending_q) begin
                load_pending_d = 1'b0;
            end else if (tick_c) begin
                scan_cnt_d = '0;
                idx_d      = wrap_c ? '0 : idx_q + IDX_W'(1);
            end else begin
                scan_cnt_d = scan_cnt_q + SCAN_W'(1);
            end

            if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end

            // Nothing is lit until the first snapshot has landed.
            if (!load_pending_q) begin
                an_d  = ~(NUM_DIGITS'(1) << idx_q);
                seg_d = (lz_blank_c || blink_blank_c) ? SEG_BLANK : dec_seg_c;
                dp_d  = blink_blank_c || !sh_dp_q[idx_q];
            end
        end

        if (snap_c) begin
            sh_digits_d = digits_bcd;
            sh_dp_d     = dp_in;
            sh_blink_d  = blink_en;
            sh_lz_d     = blank_lz;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q     <= '0;
            idx_q          <= '0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            load_pending_q <= 1'b1;
            sh_digits_q    <= '0;
            sh_dp_q        <= '0;
            sh_blink_q     <= '0;
            sh_lz_q        <= 1'b0;
            seg            <= SEG_BLANK;
            dp             <= 1'b1;
            an             <= '1;
            frame_done     <= 1'b0;
        end else begin
            scan_cnt_q     <= scan_cnt_d;
            idx_q          <= idx_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
            load_pending_q <= load_pending_d;
            sh_digits_q    <= sh_digits_d;
            sh_dp_q        <= sh_dp_d;
            sh_blink_q     <= sh_blink_d;
            sh_lz_q        <= sh_lz_d;
            seg            <= seg_d;
            dp             <= dp_d;
            an             <= an_d;
            frame_done     <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: behavioural display model compared
// every cycle, plus hand-computed expectations for the directed scenarios.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] digits_bcd;
    logic [3:0]  dp_in;
    logic [3:0]  blink_en;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_HALF(BH)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digits_bcd (digits_bcd),
        .dp_in      (dp_in),
        .blink_en   (blink_en),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which digit is shown, for how long, and from which frame copy.
    int         m_dig[N];
    bit         m_dp[N];
    bit         m_bl[N];
    bit         m_lz;
    int         pos, dwell, bcnt;
    bit         phase, pending;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_dp, exp_fd, exp_phase;

    always @(posedge clk) begin
        bit lz, bb, snap;
        if (reset) begin
            pos = 0; dwell = 0; bcnt = 0; phase = 0; pending = 1;
            for (int j = 0; j < N; j++) begin m_dig[j] = 0; m_dp[j] = 0; m_bl[j] = 0; end
            m_lz = 0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0; exp_phase = 1'b0;
        end else begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_phase = phase;
            if (enable && !pending) begin
                exp_an = 4'hF & ~(4'(1) << pos);
                lz = m_lz && (pos > 0);
                for (int j = pos; j < N; j++) if (m_dig[j] != 0) lz = 0;
                bb = phase && m_bl[pos];
                exp_seg = (lz || bb) ? 7'h7F : dec(m_dig[pos]);
                exp_dp  = bb ? 1'b1 : !m_dp[pos];
            end
            snap = enable && (pending || (dwell == SD - 1 && pos == N - 1));
            exp_fd = snap;
            if (snap) begin
                for (int j = 0; j < N; j++) begin
                    m_dig[j] = int'(digits_bcd[4*j +: 4]);
                    m_dp[j]  = dp_in[j];
                    m_bl[j]  = blink_en[j];
                end
                m_lz = blank_lz;
            end
            if (enable) begin
                if (pending) pending = 0;
                else begin
                    dwell++;
                    if (dwell == SD) begin dwell = 0; pos = (pos + 1) % N; end
                end
                bcnt++;
                if (bcnt == BH) begin bcnt = 0; phase = !phase; end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_an", 16'(an), 16'(exp_an));
            chk("model_seg", 16'(seg), 16'(exp_seg));
            chk("model_dp", 16'(dp), 16'(exp_dp));
            chk("model_frame_done", 16'(frame_done), 16'(exp_fd));
        end
    end

    task automatic wait_an(input logic [3:0] target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an !== target && n < 64);
        chk("wait_an", 16'(an), 16'(target));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; digits_bcd = 16'h1234;
        dp_in = '0; blink_en = '0; blank_lz = 1'b0;

        repeat (3) @(negedge clk);
        cmp_on = 1'b1;
        chk("reset_an", 16'(an), 16'hF);
        chk("reset_seg", 16'(seg), 16'h7F);
        chk("reset_dp", 16'(dp), 16'h1);
        chk("reset_fd", 16'(frame_done), 16'h0);

        reset = 1'b0;
        @(negedge clk);
        chk("release_an_dark", 16'(an), 16'hF);
        chk("release_fd", 16'(frame_done), 16'h1);
        @(negedge clk);
        chk("first_an", 16'(an), 16'hE);
        chk("first_seg", 16'(seg), 16'h19);

        // Scan order, four cycles per digit
        repeat (4) @(negedge clk);
        chk("scan_an1", 16'(an), 16'hD); chk("scan_seg1", 16'(seg), 16'h30);
        repeat (4) @(negedge clk);
        chk("scan_an2", 16'(an), 16'hB); chk("scan_seg2", 16'(seg), 16'h24);
        repeat (4) @(negedge clk);
        chk("scan_an3", 16'(an), 16'h7); chk("scan_seg3", 16'(seg), 16'h79);
        repeat (3) @(negedge clk);
        chk("frame_pulse", 16'(frame_done), 16'h1);
        @(negedge clk);
        chk("wrap_an", 16'(an), 16'hE); chk("wrap_fd_low", 16'(frame_done), 16'h0);

        // Snapshot coherence
        wait_an(4'b1101);
        digits_bcd = 16'h5678;
        wait_an(4'b1011); chk("coh_d2_old", 16'(seg), 16'h24);
        wait_an(4'b0111); chk("coh_d3_old", 16'(seg), 16'h79);
        wait_an(4'b1110); chk("coh_d0_new", 16'(seg), 16'h00);
        wait_an(4'b1101); chk("coh_d1_new", 16'(seg), 16'h78);
        wait_an(4'b1011); chk("coh_d2_new", 16'(seg), 16'h02);
        wait_an(4'b0111); chk("coh_d3_new", 16'(seg), 16'h12);

        // Leading zeros (inputs change while digit 3 is lit, ahead of the next snapshot)
        blank_lz = 1'b1; digits_bcd = 16'h0045;
        wait_an(4'b1110); chk("lz_d0", 16'(seg), 16'h12);
        wait_an(4'b1101); chk("lz_d1", 16'(seg), 16'h19);
        wait_an(4'b1011); chk("lz_d2_blank", 16'(seg), 16'h7F); chk("lz_d2_dp", 16'(dp), 16'h1);
        wait_an(4'b0111); chk("lz_d3_blank", 16'(seg), 16'h7F);
        digits_bcd = 16'h0000;
        wait_an(4'b1110); chk("lz_zero_d0", 16'(seg), 16'h40);
        wait_an(4'b1101); chk("lz_zero_d1", 16'(seg), 16'h7F);
        wait_an(4'b0111);
        blank_lz = 1'b0; digits_bcd = 16'h0045;
        wait_an(4'b1011); chk("nolz_d2", 16'(seg), 16'h40);
        wait_an(4'b0111); chk("nolz_d3", 16'(seg), 16'h40);

        // Invalid code, decimal point and blink over several blink half-periods
        digits_bcd = 16'h00A1; dp_in = 4'b0010; blink_en = 4'b0001;
        for (int f = 0; f < 6; f++) begin
            wait_an(4'b1110);
            chk("blink_d0", 16'(seg), exp_phase ? 16'h7F : 16'h79);
            chk("blink_d0_dp", 16'(dp), 16'h1);
            wait_an(4'b1101);
            chk("dash_d1", 16'(seg), 16'h3F);
            chk("dp_d1", 16'(dp), 16'h0);
        end
        dp_in = '0; blink_en = '0;

        // Enable drop while digit 2 is lit
        wait_an(4'b1011);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_an", 16'(an), 16'hF); chk("dis_seg", 16'(seg), 16'h7F); chk("dis_dp", 16'(dp), 16'h1);
        repeat (3) @(negedge clk);
        chk("dis_hold_an", 16'(an), 16'hF);
        enable = 1'b1;
        @(negedge clk);
        chk("reen_an", 16'(an), 16'hB);

        // Randomized traffic, including enable dropouts
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                for (int j = 0; j < N; j++)
                    digits_bcd[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                dp_in    = 4'($urandom_range(0, 15));
                blink_en = 4'($urandom_range(0, 15));
                blank_lz = 1'($urandom_range(0, 1));
            end
            enable = ($urandom_range(0, 24) != 0);
        end
        enable = 1'b1;

        // Reset mid-frame while digit 3 is lit
        wait_an(4'b0111);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_an", 16'(an), 16'hF); chk("mrst_seg", 16'(seg), 16'h7F);
        chk("mrst_dp", 16'(dp), 16'h1); chk("mrst_fd", 16'(frame_done), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_rel_an", 16'(an), 16'hF); chk("mrst_rel_fd", 16'(frame_done), 16'h1);
        @(negedge clk);
        chk("mrst_first_an", 16'(an), 16'hE);
        repeat (4) @(negedge clk);

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
